mult_seq_alu: RTL
=================

Name: mult_seq_alu

Overview:
- Multi-cycle unsigned shift-add multiplier. It is the initiator for the shared 32-bit combinational ALU: it drives the ALU operands and op select, and consumes the ALU result and zero flag.
- It produces the low 32 bits of op_a*op_b, which is the MIPS `mul` semantics.
- Sits in the EX stage beside the ALU. The multi-cycle controller starts it and stalls on busy.

Parameters:
WIDTH, 32, datapath width; must equal the ALU width.
ADD_OP, 3'b010, ALU op encoding {op2,op1,op0} for ADD (op2=0, so no invert and carry-in 0).

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
start  in  1  request; sampled only in IDLE.
op_a  in  WIDTH  multiplicand, captured on accepted start.
op_b  in  WIDTH  multiplier, captured on accepted start.
busy  out  1  high while in RUN or FIN.
done  out  1  one-cycle pulse; product/zero valid.
product  out  WIDTH  low WIDTH bits of op_a*op_b; held until next completion.
zero  out  1  1 when product==0; held with product.
alu_a  out  WIDTH  ALU operand A.
alu_b  out  WIDTH  ALU operand B.
alu_op2, alu_op1, alu_op0  out  1 each  ALU op select.
alu_result  in  WIDTH  ALU result (combinational from alu_a/alu_b/op).
alu_zero  in  1  ALU zero flag (1 when alu_result==0).

Behaviour:
- Reset (async, reset_n=0): state=IDLE; acc, mcand, mplier, product=0; zero=0; done=0; busy=0.
- ALU drive is a combinational mux of internal registers:
  - RUN: alu_a=acc, alu_b=mcand.
  - FIN: alu_a=acc, alu_b=0.
  - IDLE: alu_a=0, alu_b=0.
  - op={alu_op2,alu_op1,alu_op0}=ADD_OP in all states.
- IDLE: on start=1, load mcand=op_a, mplier=op_b, acc=0, go to RUN. Otherwise hold. done is cleared in any cycle it is not being set.
- RUN, each cycle:
  - If mplier[0]=1, acc<=alu_result (acc+mcand, wraps mod 2^WIDTH, no carry-out). Else acc holds.
  - mcand<=mcand<<1; mplier<=mplier>>1 (zero fill).
  - If (mplier>>1)==0, go to FIN (early termination). Otherwise stay in RUN.
- FIN (one cycle): product<=acc; zero<=alu_zero (acc+0 through the ALU); done<=1; go to IDLE.
- Latency: let N = max(1, index of highest set bit of op_b + 1).
  - start sampled at edge k; done high in the cycle after edge k+N+1.
  - busy is high from after edge k through edge k+N+1.
  - op_b=0 gives 2 edges; op_b=0xFFFFFFFF gives 33 edges.
- start while busy: ignored; no queuing, operands not re-sampled.
- start in the same cycle done is high: accepted, because state is already IDLE. product/zero hold old values until the new FIN.
- op_a/op_b changing after acceptance: no effect.
- Overflow: upper product bits are discarded; no flag.
- Reset asserted mid-operation: immediate abort to reset values. No done pulse. Result lost.
- alu_result/alu_zero are used only in RUN (result) and FIN (zero). Values in other states are don't-care.

Test Plan:
- Reset mid-RUN: start op_a=7, op_b=0x80000000, assert reset_n=0 after 5 cycles → busy=0, done=0, product=0 immediately. Next op_a=3, op_b=4 → product=12.
- Basic: op_a=6, op_b=7 → done exactly 4 edges after start edge (N=3), product=42, zero=0. busy high 4 cycles. alu_op={0,1,0} throughout.
- Zero multiplier: op_a=0x1234, op_b=0 → done after 2 edges, product=0, zero=1.
- Full length with wrap: op_a=0xFFFFFFFF, op_b=0xFFFFFFFF → done after 33 edges, product=0x00000001, zero=0. Also op_a=0x10000, op_b=0x10000 → product=0, zero=1.
- Handshake: pulse start during busy with different operands → ignored, original result returned. Raise start in the done cycle with op_a=5, op_b=5 → accepted, second done with product=25.
- Random: 1000 random op_a/op_b, back-to-back → product == (op_a*op_b) mod 2^32, zero == (product==0), latency matches N+1 per transaction.

Source files
------------

// File: rtl/mult_seq_alu_if.sv
// ---------------------------------------------------------------------------
// mult_seq_alu_if
// Purpose : bundles the controller handshake and the shared-ALU bus of the
//           sequential multiplier into one interface.
// Signals :
//   start/op_a/op_b             controller -> multiplier request + operands
//   busy/done/product/zero      multiplier -> controller status and result
//   alu_a/alu_b/alu_op2..0      multiplier -> ALU operands and op select
//   alu_result/alu_zero         ALU -> multiplier (combinational)
// Modports:
//   slave  : the multiplier itself
//   master : the surrounding environment (controller + ALU)
// ---------------------------------------------------------------------------
interface mult_seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic             zero;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_op2;
  logic             alu_op1;
  logic             alu_op0;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  modport slave (
    input  start, op_a, op_b, alu_result, alu_zero,
    output busy, done, product, zero, alu_a, alu_b, alu_op2, alu_op1, alu_op0
  );

  modport master (
    output start, op_a, op_b, alu_result, alu_zero,
    input  busy, done, product, zero, alu_a, alu_b, alu_op2, alu_op1, alu_op0
  );
endinterface

// File: rtl/mult_seq_alu.sv
// ---------------------------------------------------------------------------
// mult_seq_alu
// Purpose : multi-cycle unsigned shift-add multiplier returning the low
//           WIDTH bits of op_a*op_b. All additions go through the shared
//           combinational ALU, which this block drives as initiator.
// Ports   :
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      mult_seq_alu_if.slave (handshake, result, ALU bus)
// Latency : N+1 edges from accepted start to done, N = max(1, msb(op_b)+1).
// ---------------------------------------------------------------------------
module mult_seq_alu #(
  parameter int          WIDTH  = 32,
  parameter logic [2:0]  ADD_OP = 3'b010
) (
  input  logic               clk,
  input  logic               reset_n,
  mult_seq_alu_if.slave      bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] product_q;
  logic             zero_q;
  logic             done_q;
  logic             busy_q;
  logic [WIDTH-1:0] alu_a_d;
  logic [WIDTH-1:0] alu_b_d;
  logic             last_step_s;

  // Early termination: no set bits remain once the current bit is consumed.
  assign last_step_s = ((mplier_q >> 1) == {WIDTH{1'b0}});

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_step_s) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ALU operand mux; the op select is ADD in every state.
  always_comb begin
    alu_a_d = {WIDTH{1'b0}};
    alu_b_d = {WIDTH{1'b0}};
    case (state_q)
      ST_RUN: begin
        alu_a_d = acc_q;
        alu_b_d = mcand_q;
      end
      ST_FIN: begin
        // acc + 0 lets the ALU zero flag report on the final product.
        alu_a_d = acc_q;
        alu_b_d = {WIDTH{1'b0}};
      end
      default: begin
        alu_a_d = {WIDTH{1'b0}};
        alu_b_d = {WIDTH{1'b0}};
      end
    endcase
  end

  // Datapath and registered status/result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= {WIDTH{1'b0}};
      mcand_q   <= {WIDTH{1'b0}};
      mplier_q  <= {WIDTH{1'b0}};
      product_q <= {WIDTH{1'b0}};
      zero_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mcand_q  <= bus.op_a;
            mplier_q <= bus.op_b;
            acc_q    <= {WIDTH{1'b0}};
            busy_q   <= 1'b1;
          end
        end
        ST_RUN: begin
          done_q <= 1'b0;
          if (mplier_q[0]) begin
            acc_q <= bus.alu_result;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
        end
        ST_FIN: begin
          product_q <= acc_q;
          zero_q    <= bus.alu_zero;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign bus.zero    = zero_q;
  assign bus.alu_a   = alu_a_d;
  assign bus.alu_b   = alu_b_d;
  assign bus.alu_op2 = ADD_OP[2];
  assign bus.alu_op1 = ADD_OP[1];
  assign bus.alu_op0 = ADD_OP[0];

endmodule
